// File: rtl/work_ctrl_mlane_if.sv
// Work-path bundle between the multi-lane sweep controller and its neighbours:
// configurator parameters and clear handshake in, per-lane beat data out.
interface work_ctrl_mlane_if #(
    parameter int NNW   = 12,
    parameter int LANES = 4,
    parameter int SW    = 24
);
    logic                      tik;
    logic                      enable;
    logic                      clear_req;
    logic                      clear_done;
    logic [NNW-1:0]            neu_num;
    logic [SW/3-1:0]           x_dim;
    logic [SW/3-1:0]           y_dim;
    logic                      stall;
    logic [LANES-1:0]          lane_vld;
    logic [LANES-1:0][NNW-1:0] lane_addr;
    logic [LANES-1:0][SW-1:0]  lane_neuid;
    logic                      lane_clear;
    logic                      busy;
    logic                      tik_overrun;

    modport master (
        output tik, enable, clear_req, neu_num, x_dim, y_dim, stall,
        input  clear_done, lane_vld, lane_addr, lane_neuid, lane_clear, busy, tik_overrun
    );

    modport slave (
        input  tik, enable, clear_req, neu_num, x_dim, y_dim, stall,
        output clear_done, lane_vld, lane_addr, lane_neuid, lane_clear, busy, tik_overrun
    );
endinterface

// File: rtl/work_ctrl_mlane.sv
// Multi-lane timestep sweep controller: presents LANES consecutive neurons per
// beat with their {z,y,x} spike IDs, honours spk_out stall, queues one early
// tik and one clear request, and runs clear sweeps that write zero.
module work_ctrl_mlane #(
    parameter int NNW   = 12,
    parameter int LANES = 4,
    parameter int SW    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    work_ctrl_mlane_if.slave bus
);
    localparam int CW = SW / 3;
    localparam int BW = NNW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;
    state_t r_state, w_state_nx;

    logic [BW-1:0]  r_base, w_base_nx;
    logic [CW-1:0]  r_x, r_y, r_z, w_x_nx, w_y_nx, w_z_nx;
    logic [NNW-1:0] r_neu_num, w_neu_nx;
    logic [CW-1:0]  r_x_dim, r_y_dim, w_xdim_nx, w_ydim_nx;
    logic           r_tik_q, r_clr_q;
    logic           r_tik_pend, r_clr_pend, w_tik_pend_nx, w_clr_pend_nx;
    logic           r_ovr, w_ovr_nx, w_done_nx;
    logic           w_start, w_adv, w_last, w_act_nx;
    logic [CW:0]    w_x_inc, w_y_inc;

    logic [LANES-1:0]          r_lane_vld, w_vld_nx;
    logic [LANES-1:0][NNW-1:0] r_lane_addr, w_addr_nx;
    logic [LANES-1:0][SW-1:0]  r_lane_neuid, w_neuid_nx;
    logic                      r_lane_clear, r_busy, r_done;

    // The beat on the outputs is the last one once its top lane reaches neu_num.
    assign w_last  = ({1'b0, r_base} + (BW+1)'(LANES)) >= (BW+1)'(r_neu_num);
    assign w_x_inc = {1'b0, r_x} + (CW+1)'(LANES);
    assign w_y_inc = {1'b0, r_y} + (CW+1)'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Next state, beat counters and event flags; everything holds by default.
    always_comb begin
        w_state_nx    = r_state;
        w_base_nx     = r_base;
        w_x_nx        = r_x;
        w_y_nx        = r_y;
        w_z_nx        = r_z;
        w_neu_nx      = r_neu_num;
        w_xdim_nx     = r_x_dim;
        w_ydim_nx     = r_y_dim;
        w_tik_pend_nx = r_tik_pend;
        w_clr_pend_nx = r_clr_pend;
        w_ovr_nx      = r_ovr;
        w_done_nx     = 1'b0;
        w_start       = 1'b0;
        w_adv         = 1'b0;
        case (r_state)
            IDLE: begin
                // Clear wins; a tik seen alongside it is kept for afterwards.
                if (r_clr_q || r_clr_pend) begin
                    w_state_nx    = CLEAR;
                    w_start       = 1'b1;
                    w_clr_pend_nx = 1'b0;
                    w_tik_pend_nx = r_tik_pend | r_tik_q;
                    w_ovr_nx      = 1'b0;
                end else if (r_tik_q || r_tik_pend) begin
                    w_tik_pend_nx = 1'b0;
                    if (bus.enable && bus.neu_num != '0) begin
                        w_state_nx = SCAN;
                        w_start    = 1'b1;
                    end
                end
            end
            default: begin
                if (r_tik_q) begin
                    if (r_tik_pend) w_ovr_nx      = 1'b1;
                    else            w_tik_pend_nx = 1'b1;
                end
                if (r_clr_q) w_clr_pend_nx = 1'b1;
                // Clear beats write zero and never wait on spk_out.
                if (r_state == CLEAR || !bus.stall) begin
                    if (w_last) begin
                        w_state_nx = IDLE;
                        w_done_nx  = (r_state == CLEAR);
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
        endcase
        if (w_start) begin
            w_base_nx = '0;
            w_x_nx    = '0;
            w_y_nx    = '0;
            w_z_nx    = '0;
            w_neu_nx  = bus.neu_num;
            w_xdim_nx = bus.x_dim;
            w_ydim_nx = bus.y_dim;
        end
        if (w_adv) begin
            w_base_nx = r_base + BW'(LANES);
            if (w_x_inc >= {1'b0, r_x_dim}) begin
                w_x_nx = '0;
                if (w_y_inc >= {1'b0, r_y_dim}) begin
                    w_y_nx = '0;
                    w_z_nx = r_z + 1'b1;
                end else begin
                    w_y_nx = w_y_inc[CW-1:0];
                end
            end else begin
                w_x_nx = w_x_inc[CW-1:0];
            end
        end
    end

    // Counters, latched sweep parameters, input event capture and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_neu_num  <= '0;
            r_x_dim    <= '0;
            r_y_dim    <= '0;
            r_tik_q    <= 1'b0;
            r_clr_q    <= 1'b0;
            r_tik_pend <= 1'b0;
            r_clr_pend <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_base     <= w_base_nx;
            r_x        <= w_x_nx;
            r_y        <= w_y_nx;
            r_z        <= w_z_nx;
            r_neu_num  <= w_neu_nx;
            r_x_dim    <= w_xdim_nx;
            r_y_dim    <= w_ydim_nx;
            r_tik_q    <= bus.tik;
            r_clr_q    <= bus.clear_req;
            r_tik_pend <= w_tik_pend_nx;
            r_clr_pend <= w_clr_pend_nx;
            r_ovr      <= w_ovr_nx;
        end
    end

    assign w_act_nx = (w_state_nx != IDLE);

    // Per-lane view of the next beat; lanes past neu_num are masked off.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BW-1:0] w_idx;
        assign w_idx         = w_base_nx + BW'(k);
        assign w_vld_nx[k]   = w_act_nx && (w_idx < BW'(w_neu_nx));
        assign w_addr_nx[k]  = w_act_nx ? w_idx[NNW-1:0] : '0;
        assign w_neuid_nx[k] = w_act_nx ? SW'({w_z_nx, w_y_nx, CW'(w_x_nx + CW'(k))}) : '0;
    end

    // Output registers load the next beat so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_vld   <= '0;
            r_lane_addr  <= '0;
            r_lane_neuid <= '0;
            r_lane_clear <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_lane_vld   <= w_vld_nx;
            r_lane_addr  <= w_addr_nx;
            r_lane_neuid <= w_neuid_nx;
            r_lane_clear <= (w_state_nx == CLEAR);
            r_busy       <= w_act_nx;
            r_done       <= w_done_nx;
        end
    end

    assign bus.lane_vld    = r_lane_vld;
    assign bus.lane_addr   = r_lane_addr;
    assign bus.lane_neuid  = r_lane_neuid;
    assign bus.lane_clear  = r_lane_clear;
    assign bus.busy        = r_busy;
    assign bus.clear_done  = r_done;
    assign bus.tik_overrun = r_ovr;
endmodule

// File: tb/tb_work_ctrl_mlane.sv
// Bench for work_ctrl_mlane: directed scenarios plus randomized sweeps, with
// expected beats derived arithmetically from the beat index.
module tb_work_ctrl_mlane;
    localparam int NNW = 12;
    localparam int L   = 4;
    localparam int SW  = 24;
    localparam int CW  = SW / 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc, wt;

    work_ctrl_mlane_if #(.NNW(NNW), .LANES(L), .SW(SW)) bus ();

    work_ctrl_mlane #(.NNW(NNW), .LANES(L), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic setp(input int neu, input int xd, input int yd);
        bus.neu_num = NNW'(neu);
        bus.x_dim   = CW'(xd);
        bus.y_dim   = CW'(yd);
        bus.enable  = 1'b1;
    endtask

    task automatic pulse(input bit t, input bit c);
        bus.tik = t;
        bus.clear_req = c;
        @(negedge clk);
        bus.tik = 1'b0;
        bus.clear_req = 1'b0;
    endtask

    task automatic idle_chk(input int n, input string tg);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            chk(tg, bus.busy, 1'b0);
        end
    endtask

    // Follows one sweep beat by beat. Expected beat i: base=i*L, x=base%xd,
    // y=(base/xd)%yd, z=base/(xd*yd). Parameters are scrambled while busy to
    // show they were latched at sweep start, then restored.
    task automatic sweep(input string tg, input int neu, input int xd, input int yd,
                         input bit clr, input int pct, input int st_beat, input int st_len,
                         input int tk_a, input int tk_b, output int ncyc, output int nwt);
        int nb, i, held, base;
        bit st;
        logic [L-1:0]          ev;
        logic [L-1:0][NNW-1:0] ea;
        logic [L-1:0][SW-1:0]  en;
        nb = (neu == 0) ? 1 : (neu + L - 1) / L;
        i = 0; held = 0; ncyc = 0; nwt = 0;
        while (bus.busy !== 1'b1 && nwt < 20) begin
            @(negedge clk);
            nwt++;
        end
        chk({tg, "_start"}, bus.busy, 1'b1);
        if (bus.busy === 1'b1) begin
            while (i < nb && ncyc < 4000) begin
                base = i * L;
                for (int k = 0; k < L; k++) begin
                    ev[k] = (base + k < neu);
                    ea[k] = NNW'(base + k);
                    en[k] = {CW'(base / (xd * yd)), CW'((base / xd) % yd), CW'(base % xd + k)};
                end
                chk({tg, "_busy"}, bus.busy, 1'b1);
                chk({tg, "_vld"}, bus.lane_vld, ev);
                chk({tg, "_addr"}, bus.lane_addr, ea);
                chk({tg, "_neuid"}, bus.lane_neuid, en);
                chk({tg, "_clr"}, bus.lane_clear, clr);
                if (i == st_beat && held < st_len) begin
                    st = 1'b1;
                    held++;
                end else begin
                    st = (pct > 0) && ($urandom_range(0, 99) < pct);
                end
                bus.stall   = st;
                bus.tik     = (ncyc == tk_a) || (ncyc == tk_b);
                bus.neu_num = NNW'($urandom);
                bus.x_dim   = CW'($urandom);
                bus.y_dim   = CW'($urandom);
                bus.enable  = 1'($urandom);
                @(negedge clk);
                ncyc++;
                if (clr || !st) i++;
            end
            chk({tg, "_beats"}, i, nb);
        end
        bus.stall = 1'b0;
        bus.tik = 1'b0;
        setp(neu, xd, yd);
        chk({tg, "_end_busy"}, bus.busy, 1'b0);
        chk({tg, "_end_vld"}, bus.lane_vld, '0);
        chk({tg, "_done"}, bus.clear_done, clr);
    endtask

    initial begin
        bus.tik = 1'b0; bus.clear_req = 1'b0; bus.stall = 1'b0;
        setp(10, 4, 2);
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_vld", bus.lane_vld, '0);
        chk("rst_addr", bus.lane_addr, '0);
        chk("rst_neuid", bus.lane_neuid, '0);
        chk("rst_clr", bus.lane_clear, 1'b0);
        chk("rst_done", bus.clear_done, 1'b0);
        chk("rst_ovr", bus.tik_overrun, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic scan
        pulse(1, 0);
        chk("basic_lat0", bus.busy, 1'b0);
        sweep("basic", 10, 4, 2, 0, 0, -1, 0, -1, -1, cyc, wt);
        chk("basic_wait", wt, 1);
        chk("basic_cyc", cyc, 3);
        idle_chk(2, "basic_idle");

        // backpressure on beat 1
        pulse(1, 0);
        sweep("bp", 10, 4, 2, 0, 0, 1, 5, -1, -1, cyc, wt);
        chk("bp_cyc", cyc, 8);
        idle_chk(2, "bp_idle");

        // one queued tik
        pulse(1, 0);
        sweep("q1", 10, 4, 2, 0, 0, -1, 0, 0, -1, cyc, wt);
        sweep("q1b", 10, 4, 2, 0, 0, -1, 0, -1, -1, cyc, wt);
        chk("q1_gap", wt, 1);
        chk("q1_ovr", bus.tik_overrun, 1'b0);
        idle_chk(5, "q1_idle");

        // two tiks mid-sweep: overrun, one extra sweep only
        pulse(1, 0);
        sweep("q2", 10, 4, 2, 0, 0, -1, 0, 0, 1, cyc, wt);
        sweep("q2b", 10, 4, 2, 0, 0, -1, 0, -1, -1, cyc, wt);
        chk("q2_gap", wt, 1);
        idle_chk(5, "q2_idle");
        chk("q2_ovr", bus.tik_overrun, 1'b1);

        // clear sweep with stall held
        bus.stall = 1'b1;
        pulse(0, 1);
        sweep("clr", 10, 4, 2, 1, 100, -1, 0, -1, -1, cyc, wt);
        chk("clr_cyc", cyc, 3);
        @(negedge clk);
        chk("clr_done_len", bus.clear_done, 1'b0);
        chk("clr_ovr", bus.tik_overrun, 1'b0);
        idle_chk(2, "clr_idle");

        // tik and clear together: clear first, then scan
        pulse(1, 1);
        sweep("sim_c", 10, 4, 2, 1, 0, -1, 0, -1, -1, cyc, wt);
        sweep("sim_s", 10, 4, 2, 0, 0, -1, 0, -1, -1, cyc, wt);
        chk("sim_gap", wt, 1);
        idle_chk(3, "sim_idle");

        // null sweeps
        bus.enable = 1'b0;
        pulse(1, 0);
        idle_chk(5, "nul_en");
        setp(0, 4, 2);
        pulse(1, 0);
        idle_chk(5, "nul_neu");
        setp(1, 4, 2);
        pulse(1, 0);
        sweep("one", 1, 4, 2, 0, 0, -1, 0, -1, -1, cyc, wt);
        chk("one_cyc", cyc, 1);
        setp(0, 4, 2);
        pulse(0, 1);
        sweep("clr0", 0, 4, 2, 1, 0, -1, 0, -1, -1, cyc, wt);
        chk("clr0_cyc", cyc, 1);
        idle_chk(2, "clr0_idle");

        // long sweep: z wraps past 255
        setp(1100, 4, 1);
        pulse(1, 0);
        sweep("zwrap", 1100, 4, 1, 0, 0, -1, 0, -1, -1, cyc, wt);
        chk("zwrap_cyc", cyc, 275);
        idle_chk(2, "zwrap_idle");

        // reset during beat 1 with a tik pending
        setp(10, 4, 2);
        pulse(1, 0);
        @(negedge clk);
        chk("ra_b0", bus.busy, 1'b1);
        bus.tik = 1'b1;
        @(negedge clk);
        bus.tik = 1'b0;
        bus.stall = 1'b1;
        @(negedge clk);
        chk("ra_b1_addr", bus.lane_addr, {12'd7, 12'd6, 12'd5, 12'd4});
        rst_n = 1'b0;
        #1;
        chk("ra_busy", bus.busy, 1'b0);
        chk("ra_vld", bus.lane_vld, '0);
        chk("ra_addr", bus.lane_addr, '0);
        chk("ra_neuid", bus.lane_neuid, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        idle_chk(8, "ra_idle");

        // randomized sweeps
        for (int r = 0; r < 16; r++) begin
            int neu, xd, yd, pct;
            bit clr;
            neu = $urandom_range(1, 40);
            xd  = L * $urandom_range(1, 3);
            yd  = $urandom_range(1, 3);
            pct = $urandom_range(0, 60);
            clr = ($urandom_range(0, 4) == 0);
            setp(neu, xd, yd);
            pulse(!clr, clr);
            sweep("rnd", neu, xd, yd, clr, pct, -1, 0, -1, -1, cyc, wt);
            chk("rnd_wait", wt, 1);
            idle_chk(2, "rnd_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
